perceptron_trainer: RTL

- Write-side engine of the bias-free neural predictor. It takes resolved branches: the 16 weights read at prediction time, the 16 table indices, the global history and the actual outcome.
- It recomputes the perceptron output and decides whether training is needed. When it is, it produces saturated weight updates plus the table write enable and write indices.
- It owns an adaptive training threshold (theta) with a confidence counter, and a mispredict statistic.
- Fully pipelined with 2-cycle latency. It accepts one branch per cycle and drives the perceptron table's update port directly.

---
 rtl/perceptron_trainer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/perceptron_trainer.sv
// Write-side engine of the bias-free perceptron predictor. It recomputes the output
// of a resolved branch, decides whether to train, and emits saturated weight updates.

module perceptron_lane #(
    parameter int W_BITS = 3
) (
    input  logic signed [W_BITS-1:0] w_i,
    input  logic                     h_i,
    output logic signed [W_BITS:0]   term_o,
    input  logic signed [W_BITS-1:0] upd_w_i,
    input  logic                     upd_h_i,
    input  logic                     upd_outcome_i,
    output logic signed [W_BITS-1:0] upd_w_o
);
    localparam logic signed [W_BITS-1:0] W_MAX = {1'b0, {(W_BITS-1){1'b1}}};
    localparam logic signed [W_BITS-1:0] W_MIN = {1'b1, {(W_BITS-1){1'b0}}};
    localparam logic signed [W_BITS-1:0] W_ONE = 1;

    logic signed [W_BITS:0] w_ext;

    // One extra bit so that negating the most negative weight stays positive.
    assign w_ext  = {w_i[W_BITS-1], w_i};
    assign term_o = h_i ? w_ext : -w_ext;

    always_comb begin
        upd_w_o = upd_w_i;
        if (upd_h_i == upd_outcome_i) begin
            if (upd_w_i != W_MAX) upd_w_o = upd_w_i + W_ONE;
        end else begin
            if (upd_w_i != W_MIN) upd_w_o = upd_w_i - W_ONE;
        end
    end
endmodule

module perceptron_trainer #(
    parameter int LANES      = 16,
    parameter int W_BITS     = 3,
    parameter int IDX_BITS   = 10,
    parameter int THETA_W    = 6,
    parameter int THETA_INIT = 12,
    parameter int TC_BITS    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [LANES*IDX_BITS-1:0]    in_index,
    input  logic [LANES*W_BITS-1:0]      in_weights,
    input  logic [LANES-1:0]             in_history,
    input  logic                         in_outcome,
    output logic                         wr_en,
    output logic [LANES*IDX_BITS-1:0]    wr_index,
    output logic [LANES*W_BITS-1:0]      wr_weights,
    output logic [THETA_W-1:0]           theta,
    output logic [15:0]                  miss_count
);
    localparam int TERM_W = W_BITS + 1;
    localparam int SUM_W  = 8;

    localparam logic signed [TC_BITS-1:0] TC_MAX = {1'b0, {(TC_BITS-1){1'b1}}};
    localparam logic signed [TC_BITS-1:0] TC_MIN = {1'b1, {(TC_BITS-1){1'b0}}};
    localparam logic [THETA_W-1:0]        THETA_MAX = {THETA_W{1'b1}};

    logic [LANES-1:0][TERM_W-1:0] term;
    logic [LANES-1:0][W_BITS-1:0] upd_w;

    logic signed [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0]        abs_c;
    logic                    mis_c, train_c;

    logic                       s1_valid_q;
    logic [LANES*IDX_BITS-1:0]  s1_index_q;
    logic [LANES*W_BITS-1:0]    s1_weights_q;
    logic [LANES-1:0]           s1_hist_q;
    logic                       s1_outcome_q;
    logic                       s1_mis_q;
    logic                       s1_train_q;

    logic                       wr_en_q;
    logic [LANES*IDX_BITS-1:0]  wr_index_q;
    logic [LANES*W_BITS-1:0]    wr_weights_q;

    logic [THETA_W-1:0]         theta_q, theta_d;
    logic signed [TC_BITS-1:0]  tc_q, tc_d;
    logic [15:0]                miss_q, miss_d;

    // Stage 1 lanes see the incoming weights; stage 2 lanes update the captured ones.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        perceptron_lane #(.W_BITS(W_BITS)) u_lane (
            .w_i           (in_weights[i*W_BITS +: W_BITS]),
            .h_i           (in_history[i]),
            .term_o        (term[i]),
            .upd_w_i       (s1_weights_q[i*W_BITS +: W_BITS]),
            .upd_h_i       (s1_hist_q[i]),
            .upd_outcome_i (s1_outcome_q),
            .upd_w_o       (upd_w[i])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_c = sum_c + {{(SUM_W-TERM_W){term[i][TERM_W-1]}}, term[i]};
        end
    end

    assign abs_c   = sum_c[SUM_W-1] ? -sum_c : sum_c;
    assign mis_c   = ~sum_c[SUM_W-1] ^ in_outcome;
    assign train_c = mis_c | (abs_c <= SUM_W'(theta_q));

    always_ff @(posedge clk) begin
        if (rst) s1_valid_q <= 1'b0;
        else     s1_valid_q <= in_valid;
    end

    // Datapath registers carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        s1_index_q   <= in_index;
        s1_weights_q <= in_weights;
        s1_hist_q    <= in_history;
        s1_outcome_q <= in_outcome;
        s1_mis_q     <= mis_c;
        s1_train_q   <= train_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_index_q   <= '0;
            wr_weights_q <= '0;
        end else begin
            wr_en_q      <= s1_valid_q & s1_train_q;
            wr_index_q   <= s1_index_q;
            wr_weights_q <= upd_w;
        end
    end

    // Theta moves only after the confidence counter saturates in one direction.
    always_comb begin
        theta_d = theta_q;
        tc_d    = tc_q;
        miss_d  = miss_q;
        if (s1_valid_q) begin
            if (s1_mis_q) begin
                if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
                if (tc_q == TC_MAX) begin
                    if (theta_q != THETA_MAX) theta_d = theta_q + 1'b1;
                    tc_d = '0;
                end else begin
                    tc_d = tc_q + 1'b1;
                end
            end else if (s1_train_q) begin
                if (tc_q == TC_MIN) begin
                    if (theta_q != '0) theta_d = theta_q - 1'b1;
                    tc_d = '0;
                end else begin
                    tc_d = tc_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            theta_q <= THETA_W'(THETA_INIT);
            tc_q    <= '0;
            miss_q  <= '0;
        end else begin
            theta_q <= theta_d;
            tc_q    <= tc_d;
            miss_q  <= miss_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_index   = wr_index_q;
    assign wr_weights = wr_weights_q;
    assign theta      = theta_q;
    assign miss_count = miss_q;
endmodule
